// File: rtl/dense_layer_sm.sv
// Pipelined fully connected layer on signed-magnitude fixed-point words (2-cycle latency).
// Optional macro DENSE_LAYER_SAT_EN: saturate out-of-range results instead of wrapping.
module dense_layer_sm #(
    parameter int unsigned BITSIZE   = 16,
    parameter int unsigned FRAC_BITS = 11,
    parameter int unsigned N_IN      = 10,
    parameter int unsigned N_OUT     = 6
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [BITSIZE*N_IN-1:0]            x,
    input  logic [BITSIZE*N_IN*N_OUT-1:0]      w,
    input  logic [BITSIZE*N_OUT-1:0]           b,
    output logic [BITSIZE*N_OUT-1:0]           y
);

    localparam int unsigned MW = BITSIZE - 1;
    localparam int unsigned FW = 2 * MW;
    localparam int unsigned PW = FW - FRAC_BITS;
    localparam int unsigned AW = FW + $clog2(N_IN + 1) + 1;
    localparam int unsigned NP = N_IN * N_OUT;

`ifdef DENSE_LAYER_SAT_EN
    localparam logic [AW-1:0] MAX_MAG = AW'({MW{1'b1}});
`endif

    // Signed-magnitude to two's complement; a zero magnitude maps to zero regardless of sign.
    function automatic logic [AW-1:0] to_tc(input logic sgn, input logic [AW-1:0] mag);
        return sgn ? (~mag + AW'(1)) : mag;
    endfunction

    logic [PW-1:0]            prod_mag_c  [NP];
    logic [NP-1:0]            prod_sign_c;
    logic [PW-1:0]            prod_mag_q  [NP];
    logic [NP-1:0]            prod_sign_q;
    logic [BITSIZE*N_OUT-1:0] bias_q;

    // Stage 1 products: truncated magnitude, sign forced positive when the product is zero
    for (genvar j = 0; j < N_OUT; j++) begin : g_row
        for (genvar i = 0; i < N_IN; i++) begin : g_col
            localparam int unsigned K  = j * N_IN + i;
            localparam int unsigned XO = BITSIZE * i;
            localparam int unsigned WO = BITSIZE * K;

            logic [PW-1:0] mag;

            assign mag            = PW'((FW'(x[XO +: MW]) * FW'(w[WO +: MW])) >> FRAC_BITS);
            assign prod_mag_c[K]  = mag;
            assign prod_sign_c[K] = (x[XO + MW] ^ w[WO + MW]) && (mag != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NP; k++) begin
                prod_mag_q[k] <= '0;
            end
            prod_sign_q <= '0;
            bias_q      <= '0;
        end else begin
            for (int k = 0; k < NP; k++) begin
                prod_mag_q[k] <= prod_mag_c[k];
            end
            prod_sign_q <= prod_sign_c;
            bias_q      <= b;
        end
    end

    logic [AW-1:0]            acc_c [N_OUT];
    logic [AW-1:0]            abs_c [N_OUT];
    logic [MW-1:0]            mag_c [N_OUT];
    logic [BITSIZE*N_OUT-1:0] y_c;

    // Stage 2: two's-complement accumulate, then back to signed magnitude without negative zero
    always_comb begin
        y_c = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc_c[j] = '0;
            abs_c[j] = '0;
            mag_c[j] = '0;
        end
        for (int j = 0; j < N_OUT; j++) begin
            acc_c[j] = to_tc(bias_q[BITSIZE*j + MW], AW'(bias_q[BITSIZE*j +: MW]));
            for (int i = 0; i < N_IN; i++) begin
                acc_c[j] = acc_c[j] + to_tc(prod_sign_q[j*N_IN + i], AW'(prod_mag_q[j*N_IN + i]));
            end
            abs_c[j] = acc_c[j][AW-1] ? (~acc_c[j] + AW'(1)) : acc_c[j];
`ifdef DENSE_LAYER_SAT_EN
            mag_c[j] = (abs_c[j] > MAX_MAG) ? '1 : MW'(abs_c[j]);
`else
            mag_c[j] = MW'(abs_c[j]);
`endif
            y_c[BITSIZE*j +: BITSIZE] = {acc_c[j][AW-1] && (mag_c[j] != '0), mag_c[j]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
        end else begin
            y <= y_c;
        end
    end

endmodule

// File: tb/tb_dense_layer_sm.sv
// Directed-vector bench for dense_layer_sm at default parameters (wrap or DENSE_LAYER_SAT_EN build).
module tb_dense_layer_sm;

    localparam int BS = 16;
    localparam int FB = 11;
    localparam int NI = 10;
    localparam int NO = 6;
    localparam int NV = 14;

`ifdef DENSE_LAYER_SAT_EN
    localparam logic [BS-1:0] OVP   = 16'h7FFF;
    localparam logic [BS-1:0] OVN   = 16'hFFFF;
    localparam logic [BS-1:0] EDGEP = 16'h7FFF;
    localparam logic [BS-1:0] EDGEN = 16'hFFFF;
`else
    localparam logic [BS-1:0] OVP   = 16'h5000;
    localparam logic [BS-1:0] OVN   = 16'hD000;
    localparam logic [BS-1:0] EDGEP = 16'h0000;
    localparam logic [BS-1:0] EDGEN = 16'h0000;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [BS*NI-1:0]        x;
    logic [BS*NI*NO-1:0]     w;
    logic [BS*NO-1:0]        b;
    logic [BS*NO-1:0]        y;

    typedef struct {
        logic [BS*NI-1:0]    x;
        logic [BS*NI*NO-1:0] w;
        logic [BS*NO-1:0]    b;
        logic [BS*NO-1:0]    y;
    } vec_t;

    vec_t tbl [NV];
    int   checks = 0;
    int   errors = 0;

    dense_layer_sm #(
        .BITSIZE  (BS),
        .FRAC_BITS(FB),
        .N_IN     (NI),
        .N_OUT    (NO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .x    (x),
        .w    (w),
        .b    (b),
        .y    (y)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [BS*NI-1:0] xat(input int i, input logic [BS-1:0] v);
        logic [BS*NI-1:0] r;
        r = '0;
        r[BS*i +: BS] = v;
        return r;
    endfunction

    function automatic logic [BS*NI-1:0] xall(input logic [BS-1:0] v);
        logic [BS*NI-1:0] r;
        for (int i = 0; i < NI; i++) r[BS*i +: BS] = v;
        return r;
    endfunction

    function automatic logic [BS*NI*NO-1:0] wcol(input int i, input logic [BS-1:0] v);
        logic [BS*NI*NO-1:0] r;
        r = '0;
        for (int j = 0; j < NO; j++) r[BS*(j*NI + i) +: BS] = v;
        return r;
    endfunction

    function automatic logic [BS*NI*NO-1:0] wall(input logic [BS-1:0] v);
        logic [BS*NI*NO-1:0] r;
        for (int k = 0; k < NI*NO; k++) r[BS*k +: BS] = v;
        return r;
    endfunction

    function automatic logic [BS*NO-1:0] rep(input logic [BS-1:0] v);
        logic [BS*NO-1:0] r;
        for (int j = 0; j < NO; j++) r[BS*j +: BS] = v;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        x = v.x;
        w = v.w;
        b = v.b;
    endtask

    task automatic check_y(input string tag, input int idx, input logic [BS*NO-1:0] exp);
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (y[BS*j +: BS] !== exp[BS*j +: BS]) begin
                errors++;
                $display("FAIL %s %0d y[%0d]: got %h want %h", tag, idx, j, y[BS*j +: BS], exp[BS*j +: BS]);
            end
        end
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < NI*BS/32; k++)    x[32*k +: 32] = $urandom();
        for (int k = 0; k < NI*NO*BS/32; k++) w[32*k +: 32] = $urandom();
        for (int k = 0; k < NO*BS/32; k++)    b[32*k +: 32] = $urandom();
    endtask

    initial begin
        // bias pass-through, negative-zero bias reads back as zero
        tbl[0]  = '{'0, wall(16'h1234),
                    {16'h0400, 16'h8000, 16'h01F7, 16'h856E, 16'h0800, 16'h0197},
                    {16'h0400, 16'h0000, 16'h01F7, 16'h856E, 16'h0800, 16'h0197}};
        tbl[1]  = '{xat(0, 16'h0800), wcol(0, 16'h0400), '0, rep(16'h0400)};
        tbl[2]  = '{xat(0, 16'h0001), wall(16'h0001), '0, rep(16'h0000)};
        tbl[3]  = '{xat(0, 16'h8800), wcol(0, 16'h1000), rep(16'h0800), rep(16'h8800)};
        tbl[4]  = '{xat(0, 16'h8800), wcol(0, 16'h8800), '0, rep(16'h0800)};
        tbl[5]  = '{xall(16'h7800), wall(16'h7800), '0, rep(OVP)};
        tbl[6]  = '{xall(16'hF800), wall(16'h7800), '0, rep(OVN)};
        tbl[7]  = '{xat(0, 16'h8000), wcol(0, 16'h0800), rep(16'h8000), rep(16'h0000)};
        tbl[8]  = '{xat(0, 16'h0800), wcol(0, 16'h8400), rep(16'h0400), rep(16'h0000)};
        tbl[9]  = '{xat(0, 16'h0C00) | xat(1, 16'h8400),
                    wcol(0, 16'h0800) | wcol(1, 16'h0800), '0, rep(16'h0800)};
        tbl[10] = '{xat(0, 16'h7FFF), wcol(0, 16'h0800), '0, rep(16'h7FFF)};
        tbl[11] = '{xat(0, 16'h7FFF), wcol(0, 16'h0800), rep(16'h0001), rep(EDGEP)};
        tbl[12] = '{xat(0, 16'hFFFF), wcol(0, 16'h0800), rep(16'h8001), rep(EDGEN)};
        // last input element with distinct per-neuron weights: y_j = 2.0 * (j+1)*0x0100
        tbl[13] = '{xat(9, 16'h1000), '0, '0, '0};
        for (int j = 0; j < NO; j++) begin
            tbl[13].w[BS*(j*NI + 9) +: BS] = 16'((j + 1) * 256);
            tbl[13].y[BS*j +: BS]          = 16'((j + 1) * 512);
        end

        reset = 1'b1;
        randomize_inputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_y("reset_hold", k, '0);
            randomize_inputs();
        end

        reset = 1'b0;
        apply(tbl[1]);
        @(negedge clk);
        check_y("release_edge1", 0, '0);
        @(negedge clk);
        check_y("release_edge2", 0, tbl[1].y);

        for (int v = 0; v < NV; v++) begin
            apply(tbl[v]);
            @(negedge clk);
            @(negedge clk);
            check_y("vector", v, tbl[v].y);
        end

        // back-to-back vectors, each result exactly two cycles later
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) check_y("stream", k - 2, tbl[k-2].y);
            if (k < 8) apply(tbl[k]);
            @(negedge clk);
        end

        // reset while a vector is in flight: it must be discarded
        apply(tbl[1]);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_y("midreset_async", 0, '0);
        apply(tbl[4]);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_y("midreset_edge1", 0, '0);
        @(negedge clk);
        check_y("midreset_edge2", 0, tbl[4].y);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
